acce_result_writer: RTL and testbench
=====================================

Name: acce_result_writer

Overview:
Downstream stage of the convolution accelerator subsystem. It takes result words from the accelerator output stream (data/valid), buffers them in a show-ahead FIFO, and writes them to system memory over an ICB master port as consecutive 32-bit writes from a configured base address. It tracks outstanding ICB responses. When the programmed word count has been written and acknowledged, it raises a level interrupt.

Parameters:
FIFO_DEPTH, 16, result buffer depth in words (power of 2, >=2)
MAX_OUTST, 4, maximum ICB write commands awaiting response (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  single-cycle start pulse; honoured only in IDLE
cfg_base_addr  in  32  destination base byte address; bits[1:0] forced to 0
cfg_word_cnt  in  16  number of 32-bit words to write
irq_clr  in  1  clears done_irq
data_i  in  32  result word from accelerator
valid_i  in  1  data_i valid this cycle
ready_o  out  1  buffer can accept a word (= !fifo_full)
busy  out  1  high in RUN or DRAIN
done_irq  out  1  level interrupt; set on DONE entry, cleared by irq_clr or cfg_start
err_flag  out  1  sticky: any rsp_err seen in current job
ovf_flag  out  1  sticky: valid_i dropped because ready_o=0
m_icb_cmd_valid  out  1  write command valid
m_icb_cmd_ready  in  1  command accepted
m_icb_cmd_addr  out  32  write address
m_icb_cmd_read  out  1  tied 0
m_icb_cmd_wdata  out  32  FIFO head word
m_icb_cmd_wmask  out  4  tied 4'hF
m_icb_rsp_ready  out  1  tied 1
m_icb_rsp_valid  in  1  response valid
m_icb_rsp_rdata  in  32  unused
m_icb_rsp_err  in  1  response error

Behaviour:
- Reset values:
  - busy, done_irq, err_flag, ovf_flag, m_icb_cmd_valid = 0.
  - ready_o = 1.
  - m_icb_cmd_addr = 0.
  - FIFO empty; all counters 0; FSM in IDLE.
  - A reset mid-job aborts immediately. Buffered words are discarded. Outstanding responses arriving after reset are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on cfg_start. On that cycle: latch addr = {cfg_base_addr[31:2], 2'b00} and total = cfg_word_cnt; clear pushed, issued, outst, err_flag, ovf_flag, done_irq.
  - If cfg_word_cnt == 0, go IDLE -> DONE directly.
  - RUN -> DRAIN when issued == total, evaluated after the cycle's handshake.
  - DRAIN -> DONE when outst == 0.
  - DONE: done_irq = 1, then go to IDLE next cycle. done_irq stays high until irq_clr or the next cfg_start.
  - cfg_start while busy is ignored.
- Push:
  - A word is written when valid_i && ready_o && state == RUN && pushed < total; pushed then increments.
  - valid_i in IDLE, DRAIN or DONE, or after pushed == total, is discarded with no flag.
  - valid_i && !ready_o in RUN sets ovf_flag. The word is lost.
  - A push while full is refused even if a pop happens in the same cycle. ready_o depends only on the registered FIFO count.
- Command issue:
  - m_icb_cmd_valid = (state == RUN) && fifo_nonempty && outst < MAX_OUTST.
  - m_icb_cmd_wdata = FIFO head (show-ahead).
  - m_icb_cmd_addr = base + 4*issued, wrapping modulo 2^32.
  - Addr and wdata must stay stable while valid && !ready. This holds by construction because pop happens only on handshake.
  - Handshake (valid && ready): pop FIFO, issued += 1, outst += 1.
- Response:
  - Each m_icb_rsp_valid decrements outst.
  - A handshake and a response in the same cycle leave outst unchanged.
  - rsp_err sets err_flag. The job continues.
  - rsp_valid with outst == 0 is ignored; outst does not underflow.
- Latency: a word pushed at cycle N appears as m_icb_cmd_valid at cycle N+1, provided the FIFO was empty and outst < MAX_OUTST.
- Simultaneous push and pop with FIFO neither empty nor full: FIFO count is unchanged and both words stay correct.

Test Plan:
- Basic: base=0x2000_0000, cnt=4, push 0x11,0x22,0x33,0x44 back-to-back, cmd_ready=1, rsp 1 cycle later -> 4 writes to 0x2000_0000/04/08/0C with wdata 0x11..0x44, wmask=F, read=0; done_irq=1; err_flag=0.
- Backpressure: cmd_ready=0 for 20 cycles while 16 words are pushed -> ready_o=0 after the 16th word; a 17th valid_i sets ovf_flag; addr and wdata stay stable; releasing cmd_ready drains all 16 in order.
- Outstanding limit: MAX_OUTST=4, cnt=8, responses withheld -> exactly 4 commands issued, then cmd_valid=0; each response permits one more; DONE only after the 8th response.
- Error/zero count: cnt=3 with the 2nd response err=1 -> err_flag=1, all 3 writes issued, done_irq=1. Separately, cnt=0 -> done_irq within 2 cycles and no cmd_valid.
- Wrap/limits: base=0xFFFF_FFF8 (plus 0x3 in bits[1:0]), cnt=3 -> addrs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; a 4th valid_i is ignored with no ovf_flag.
- Reset mid-job: assert rst after 2 of 6 writes -> next cycle cmd_valid=0, busy=0, ready_o=1; a late rsp_valid causes no change; a new cfg_start then runs cleanly.

Source files
------------

// File: rtl/acce_result_writer.sv
// Result writer: buffers accelerator words in a show-ahead FIFO and writes them as consecutive ICB words.
// A word pushed at cycle N is offered at N+1; ready_o drops when the FIFO is full, issue stalls at MAX_OUTST.
module acce_result_writer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Full is taken from the registered count only, so a same-cycle pop never opens room for a push.
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push_vld && !full;
  assign do_pop   = pop_rdy && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end
endmodule

module acce_result_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_base_addr,
  input  logic [15:0] cfg_word_cnt,
  input  logic        irq_clr,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        busy,
  output logic        done_irq,
  output logic        err_flag,
  output logic        ovf_flag,
  output logic        m_icb_cmd_valid,
  input  logic        m_icb_cmd_ready,
  output logic [31:0] m_icb_cmd_addr,
  output logic        m_icb_cmd_read,
  output logic [31:0] m_icb_cmd_wdata,
  output logic [3:0]  m_icb_cmd_wmask,
  output logic        m_icb_rsp_ready,
  input  logic        m_icb_rsp_valid,
  input  logic [31:0] m_icb_rsp_rdata,
  input  logic        m_icb_rsp_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

  logic [1:0]  state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] total_q, total_d;
  logic [15:0] pushed_q, pushed_d;
  logic [15:0] issued_q, issued_d;
  logic [3:0]  outst_q, outst_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;

  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_head;
  logic        in_run, push_ok, ovf_hit, cmd_hs, rsp_ok;
  logic        unused_ok;

  assign unused_ok = ^{m_icb_rsp_rdata, cfg_base_addr[1:0]};

  assign in_run  = (state_q == S_RUN);
  assign ready_o = !fifo_full;
  assign push_ok = valid_i && ready_o && in_run && (pushed_q < total_q);
  // Words beyond the programmed count are silently dropped, only a real loss flags overflow.
  assign ovf_hit = valid_i && !ready_o && in_run && (pushed_q < total_q);

  assign m_icb_cmd_valid = in_run && !fifo_empty && (outst_q < OUTST_MAX);
  assign cmd_hs          = m_icb_cmd_valid && m_icb_cmd_ready;
  assign rsp_ok          = m_icb_rsp_valid && (outst_q != '0);

  assign m_icb_cmd_addr  = base_q + {14'd0, issued_q, 2'b00};
  assign m_icb_cmd_wdata = fifo_head;
  assign m_icb_cmd_read  = 1'b0;
  assign m_icb_cmd_wmask = 4'hF;
  assign m_icb_rsp_ready = 1'b1;

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_irq = irq_q;
  assign err_flag = err_q;
  assign ovf_flag = ovf_q;

  acce_result_writer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_ok),
    .push_dat (data_i),
    .pop_rdy  (cmd_hs),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    total_d  = total_q;
    pushed_d = pushed_q + 16'(push_ok);
    issued_d = issued_q + 16'(cmd_hs);
    outst_d  = outst_q + 4'(cmd_hs) - 4'(rsp_ok);
    err_d    = err_q || (rsp_ok && m_icb_rsp_err);
    ovf_d    = ovf_q || ovf_hit;
    irq_d    = irq_q && !irq_clr;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          base_d   = {cfg_base_addr[31:2], 2'b00};
          total_d  = cfg_word_cnt;
          pushed_d = '0;
          issued_d = '0;
          outst_d  = '0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          irq_d    = 1'b0;
          state_d  = (cfg_word_cnt == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued_d == total_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Setting on DONE entry wins over a coincident irq_clr.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      total_q  <= '0;
      pushed_q <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      pushed_q <= pushed_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end
endmodule

// File: tb/tb_acce_result_writer.sv
// Directed bench for acce_result_writer: captures every ICB write and compares against hand-computed values.
module tb_acce_result_writer;
  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [15:0] cfg_word_cnt;
  logic        irq_clr;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        busy;
  logic        done_irq;
  logic        err_flag;
  logic        ovf_flag;
  logic        m_icb_cmd_valid;
  logic        m_icb_cmd_ready;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_ready;
  logic        m_icb_rsp_valid;
  logic [31:0] m_icb_rsp_rdata;
  logic        m_icb_rsp_err;

  acce_result_writer #(
    .FIFO_DEPTH (16),
    .MAX_OUTST  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_base_addr   (cfg_base_addr),
    .cfg_word_cnt    (cfg_word_cnt),
    .irq_clr         (irq_clr),
    .data_i          (data_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .busy            (busy),
    .done_irq        (done_irq),
    .err_flag        (err_flag),
    .ovf_flag        (ovf_flag),
    .m_icb_cmd_valid (m_icb_cmd_valid),
    .m_icb_cmd_ready (m_icb_cmd_ready),
    .m_icb_cmd_addr  (m_icb_cmd_addr),
    .m_icb_cmd_read  (m_icb_cmd_read),
    .m_icb_cmd_wdata (m_icb_cmd_wdata),
    .m_icb_cmd_wmask (m_icb_cmd_wmask),
    .m_icb_rsp_ready (m_icb_rsp_ready),
    .m_icb_rsp_valid (m_icb_rsp_valid),
    .m_icb_rsp_rdata (m_icb_rsp_rdata),
    .m_icb_rsp_err   (m_icb_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cap_addr [32];
  logic [31:0] cap_data [32];
  int          hs_n = 0;
  int          rsp_n = 0;
  int          rel_n = 0;
  int          err_at = 0;
  bit          auto_rsp = 1'b1;
  bit          seen_vld;

  task automatic expect_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // One clock: log any handshake at the falling edge, then drive the responder just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (m_icb_cmd_valid && m_icb_cmd_ready && hs_n < 32) begin
      cap_addr[hs_n] = m_icb_cmd_addr;
      cap_data[hs_n] = m_icb_cmd_wdata;
      hs_n++;
    end
    @(posedge clk);
    #1;
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_err   = 1'b0;
    if (hs_n > rsp_n && (auto_rsp || rsp_n < rel_n)) begin
      rsp_n++;
      m_icb_rsp_valid = 1'b1;
      m_icb_rsp_err   = (rsp_n == err_at);
    end
    cfg_start = 1'b0;
    irq_clr   = 1'b0;
    valid_i   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
    tick();
    hs_n  = 0;
    rsp_n = 0;
    rel_n = 0;
    cfg_base_addr = base;
    cfg_word_cnt  = cnt;
    cfg_start     = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] d);
    valid_i = 1'b1;
    data_i  = d;
    tick();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_irq && n < budget) begin
      tick();
      n++;
    end
    expect_eq(tag, 32'(done_irq), 32'd1);
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n = 0;
    while (hs_n < target && n < budget) begin
      tick();
      n++;
    end
    expect_eq(tag, 32'(hs_n), 32'(target));
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_word_cnt = '0;
    irq_clr = 1'b0;
    data_i = '0;
    valid_i = 1'b0;
    m_icb_cmd_ready = 1'b1;
    m_icb_rsp_valid = 1'b0;
    m_icb_rsp_rdata = '0;
    m_icb_rsp_err = 1'b0;
    ticks(3);
    rst = 1'b0;

    expect_eq("rst_busy",   32'(busy), 32'd0);
    expect_eq("rst_irq",    32'(done_irq), 32'd0);
    expect_eq("rst_err",    32'(err_flag), 32'd0);
    expect_eq("rst_ovf",    32'(ovf_flag), 32'd0);
    expect_eq("rst_cvld",   32'(m_icb_cmd_valid), 32'd0);
    expect_eq("rst_ready",  32'(ready_o), 32'd1);
    expect_eq("rst_addr",   m_icb_cmd_addr, 32'h0);
    expect_eq("rst_read",   32'(m_icb_cmd_read), 32'd0);
    expect_eq("rst_wmask",  32'(m_icb_cmd_wmask), 32'hF);
    expect_eq("rst_rsprdy", 32'(m_icb_rsp_ready), 32'd1);

    // Basic four-word job
    start_job(32'h2000_0000, 16'd4);
    expect_eq("basic_busy", 32'(busy), 32'd1);
    push(32'h11);
    expect_eq("basic_lat_vld",  32'(m_icb_cmd_valid), 32'd1);
    expect_eq("basic_lat_data", m_icb_cmd_wdata, 32'h11);
    push(32'h22);
    push(32'h33);
    push(32'h44);
    wait_done("basic_done", 30);
    expect_eq("basic_hs", 32'(hs_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      expect_eq("basic_addr", cap_addr[i], 32'h2000_0000 + 32'(4 * i));
      expect_eq("basic_data", cap_data[i], 32'(32'h11 * (i + 1)));
    end
    expect_eq("basic_err", 32'(err_flag), 32'd0);
    tick();
    expect_eq("basic_irq_hold", 32'(done_irq), 32'd1);
    irq_clr = 1'b1;
    tick();
    expect_eq("basic_irq_clr", 32'(done_irq), 32'd0);

    // Backpressure: fill the buffer with the command port stalled
    m_icb_cmd_ready = 1'b0;
    start_job(32'h0000_1000, 16'd17);
    for (int i = 0; i < 16; i++) push(32'hA0 + 32'(i));
    expect_eq("bp_full", 32'(ready_o), 32'd0);
    push(32'hDEAD);
    expect_eq("bp_ovf", 32'(ovf_flag), 32'd1);
    ticks(3);
    expect_eq("bp_hold_vld",  32'(m_icb_cmd_valid), 32'd1);
    expect_eq("bp_hold_addr", m_icb_cmd_addr, 32'h0000_1000);
    expect_eq("bp_hold_data", m_icb_cmd_wdata, 32'hA0);
    m_icb_cmd_ready = 1'b1;
    wait_hs("bp_drain", 16, 60);
    push(32'hB0);
    wait_done("bp_done", 30);
    expect_eq("bp_hs", 32'(hs_n), 32'd17);
    for (int i = 0; i < 17; i++) begin
      expect_eq("bp_addr", cap_addr[i], 32'h0000_1000 + 32'(4 * i));
      expect_eq("bp_data", cap_data[i], (i < 16) ? 32'hA0 + 32'(i) : 32'hB0);
    end
    expect_eq("bp_ovf_sticky", 32'(ovf_flag), 32'd1);

    // Outstanding limit with withheld responses
    auto_rsp = 1'b0;
    start_job(32'h0000_3000, 16'd8);
    for (int i = 0; i < 8; i++) push(32'h80 + 32'(i));
    ticks(6);
    expect_eq("os_cap4",  32'(hs_n), 32'd4);
    expect_eq("os_stall", 32'(m_icb_cmd_valid), 32'd0);
    rel_n = 1;
    ticks(4);
    expect_eq("os_one_more", 32'(hs_n), 32'd5);
    expect_eq("os_stall2",   32'(m_icb_cmd_valid), 32'd0);
    rel_n = 7;
    ticks(15);
    expect_eq("os_all_issued", 32'(hs_n), 32'd8);
    expect_eq("os_not_done",   32'(done_irq), 32'd0);
    expect_eq("os_busy",       32'(busy), 32'd1);
    rel_n = 8;
    wait_done("os_done", 10);
    expect_eq("os_last_addr", cap_addr[7], 32'h0000_301C);
    expect_eq("os_last_data", cap_data[7], 32'h87);
    auto_rsp = 1'b1;

    // Error on the second response
    err_at = 2;
    start_job(32'h0000_4000, 16'd3);
    push(32'h1);
    push(32'h2);
    push(32'h3);
    wait_done("err_done", 30);
    expect_eq("err_flag", 32'(err_flag), 32'd1);
    expect_eq("err_hs",   32'(hs_n), 32'd3);
    err_at = 0;

    // Zero-length job
    start_job(32'h0000_5000, 16'd0);
    seen_vld = m_icb_cmd_valid;
    for (int i = 0; i < 2 && !done_irq; i++) begin
      tick();
      seen_vld = seen_vld | m_icb_cmd_valid;
    end
    expect_eq("zero_irq", 32'(done_irq), 32'd1);
    expect_eq("zero_err_cleared", 32'(err_flag), 32'd0);
    ticks(2);
    seen_vld = seen_vld | m_icb_cmd_valid;
    expect_eq("zero_no_cmd", 32'(seen_vld), 32'd0);

    // Address wrap and words beyond the count
    start_job(32'hFFFF_FFFB, 16'd3);
    push(32'hC1);
    push(32'hC2);
    push(32'hC3);
    push(32'hC4);
    expect_eq("wrap_no_ovf", 32'(ovf_flag), 32'd0);
    wait_done("wrap_done", 30);
    expect_eq("wrap_hs", 32'(hs_n), 32'd3);
    expect_eq("wrap_a0", cap_addr[0], 32'hFFFF_FFF8);
    expect_eq("wrap_a1", cap_addr[1], 32'hFFFF_FFFC);
    expect_eq("wrap_a2", cap_addr[2], 32'h0000_0000);
    expect_eq("wrap_d2", cap_data[2], 32'hC3);

    // Reset in the middle of a job
    auto_rsp = 1'b0;
    start_job(32'h0000_5000, 16'd6);
    push(32'h51);
    push(32'h52);
    ticks(3);
    expect_eq("mid_hs", 32'(hs_n), 32'd2);
    m_icb_cmd_ready = 1'b0;
    push(32'h53);
    push(32'h54);
    rst = 1'b1;
    tick();
    expect_eq("mid_cvld",  32'(m_icb_cmd_valid), 32'd0);
    expect_eq("mid_busy",  32'(busy), 32'd0);
    expect_eq("mid_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;
    err_at = 1;
    rel_n = 2;
    ticks(4);
    expect_eq("late_rsp_sent", 32'(rsp_n), 32'd2);
    expect_eq("late_busy", 32'(busy), 32'd0);
    expect_eq("late_err",  32'(err_flag), 32'd0);
    expect_eq("late_irq",  32'(done_irq), 32'd0);
    err_at = 0;
    auto_rsp = 1'b1;
    m_icb_cmd_ready = 1'b1;
    start_job(32'h0000_6000, 16'd2);
    push(32'h61);
    push(32'h62);
    wait_done("restart_done", 30);
    expect_eq("restart_hs", 32'(hs_n), 32'd2);
    expect_eq("restart_a0", cap_addr[0], 32'h0000_6000);
    expect_eq("restart_d0", cap_data[0], 32'h61);
    expect_eq("restart_a1", cap_addr[1], 32'h0000_6004);
    expect_eq("restart_d1", cap_data[1], 32'h62);
    expect_eq("restart_err", 32'(err_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
